// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for the EX stage (quotient -> LO, remainder -> HI).
// Signed ops divide magnitudes and fix the signs afterwards; the remainder takes the dividend's sign.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             mdsign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem, r_quo, r_bmag;
    logic             r_qneg, r_rneg, r_dbz;
    logic [WIDTH-1:0] w_amag, w_bmag, w_qn, w_rn;
    logic [WIDTH:0]   w_shift, w_diff;
    logic             w_ge, w_last;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = cancel ? IDLE :
                 (r_state == IDLE) ? (start ? RUN : IDLE) :
                 (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
    end

    // r_quo starts as the dividend magnitude; its MSBs feed the remainder while quotient bits fill from the LSB.
    always_comb begin
        w_amag  = (mdsign & dividend[WIDTH-1]) ? -dividend : dividend;
        w_bmag  = (mdsign & divisor[WIDTH-1])  ? -divisor  : divisor;
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_bmag};
        w_ge    = ~w_diff[WIDTH];
        w_rn    = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_qn    = {r_quo[WIDTH-2:0], w_ge};
        w_last  = (r_cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_bmag      <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_dbz       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (!cancel) begin
            if (r_state == IDLE && start) begin
                r_cnt  <= '0;
                r_rem  <= '0;
                r_quo  <= w_amag;
                r_bmag <= w_bmag;
                r_qneg <= mdsign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_rneg <= mdsign & dividend[WIDTH-1];
                r_dbz  <= (divisor == '0);
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + 1'b1;
                r_rem <= w_rn;
                r_quo <= w_qn;
                if (w_last) begin
                    quotient    <= r_qneg ? -w_qn : w_qn;
                    remainder   <= r_rneg ? -w_rn : w_rn;
                    div_by_zero <= r_dbz;
                end
            end
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);
endmodule
